vx_gpr_wb_file: RTL and testbench
=================================

// Module: vx_gpr_wb_file
// PURPOSE
//  Per-warp general-purpose register file; terminal consumer of the writeback
//  stage's write port (write data, rd, wb code, warp number, lane valid mask).
//  Two registered read ports (rs1/rs2) feed decode/execute. Same-cycle
//  write->read forwarding is built in. A clear engine zeroes all warps after
//  reset and one warp on request (warp spawn).
// PARAMETERS
//  NT        2   threads (lanes) per warp; each register is NT*32 bits wide
//  NW        8   warps; NWB = $clog2(NW) bits of warp number (min 1)
//  NUM_REGS  32  architectural registers per warp; r0 is hard zero
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  reset            in   1       synchronous reset, active-low (0 = reset)
//  in_wb_data       in   NT*32   write data; lane i = [32*i+31:32*i]
//  in_wb_rd         in   5       destination register
//  in_wb_wb         in   2       wb code; 2'b00 = no write, any nonzero = write
//  in_wb_valid      in   NT      per-lane write enable mask
//  in_wb_warp_num   in   NWB     destination warp
//  in_rd_warp_num   in   NWB     read warp
//  in_rs1           in   5       read port A register index
//  in_rs2           in   5       read port B register index
//  out_rs1_data     out  NT*32   port A data, 1 cycle after address
//  out_rs2_data     out  NT*32   port B data, 1 cycle after address
//  in_clear_req     in   1       pulse: zero every register of in_clear_warp
//  in_clear_warp    in   NWB     warp to clear
//  out_clear_busy   out  1       clear engine active (INIT or CLEAR)
//  out_ready        out  1       1 = IDLE, reads valid, clear request accepted
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FSM->INIT, cnt=0, out_rs1/rs2_data=0,
//    out_ready=0, out_clear_busy=1. Storage contents are not reset directly.
//  - Write qualifier: we = (in_wb_wb!=0) && (in_wb_rd!=0). Lane i is written
//    iff we && in_wb_valid[i]. Writes with rd==0 are dropped. Writes are
//    accepted in every FSM state (no stall path back to writeback).
//  - Reads: out_rsX_data <= (rsX==0) ? 0 : reg[in_rd_warp_num][rsX]; latency
//    1 cycle; reads are issued in every state.
//  - Forwarding: if we && warp/rd match the read address in the same cycle,
//    lane i returns in_wb_data lane i when in_wb_valid[i]; otherwise it
//    returns the stored value. rs1 and rs2 are forwarded independently.
//  - FSM states and transitions:
//    INIT  - zeroes reg[cnt] in all warps each cycle; cnt++; at
//            cnt==NUM_REGS-1 go to IDLE, cnt=0 (NUM_REGS cycles in total).
//    IDLE  - out_ready=1; in_clear_req latches in_clear_warp into cw and moves
//            to CLEAR with cnt=0.
//    CLEAR - zeroes reg[cw][cnt] each cycle; cnt++; at cnt==NUM_REGS-1 go to
//            IDLE. in_clear_req is ignored (dropped) outside IDLE.
//  - Collision: a clear write and a wb write to the same warp/reg in the same
//    cycle -> wb data wins on its valid lanes; other lanes are zeroed.
//  - Upstream rule (not checked in RTL): no wb to warp cw during CLEAR; a later
//    clear step overwrites it.
//  - Reset mid-INIT/CLEAR aborts the sweep, restarts INIT at cnt=0.
//  - cnt width is $clog2(NUM_REGS); no wrap past NUM_REGS-1.
// TESTING
//  1 reset low 3 cycles, then high -> out_ready=0 for 32 cycles, then 1;
//    read of any warp/reg -> 0.
//  2 wb warp2 rd5 wb=01 valid=11 data={32'hB,32'hA}; next cycle rs1=5 warp2
//    -> out_rs1_data={B,A} one cycle later.
//  3 same-cycle wb warp1 rd7 valid=01 data lane0=32'h55 and rs2=7 warp1 (old
//    {9,8}) -> out_rs2_data={9,55}; wb rd0 or wb=00 -> storage unchanged.
//  4 fill warp3 r1..r31 with nonzero data, clear_req warp3 -> busy for 32
//    cycles; warp3 reads 0; warp4 intact; second clear_req during busy dropped.
//  5 clear warp0 with wb warp0 rd=cnt in the same cycle, valid=10 data={77,66}
//    -> that reg reads {77,0}.
//  6 reset low at CLEAR cnt=10 -> INIT restarts; out_ready rises 32 cycles
//    after reset release.

Source files
------------

// File: rtl/vx_gpr_wb_file_if.sv
// Register file port bundle: writeback write port, operand read ports,
// and the warp clear request/status signals.
interface vx_gpr_wb_file_if #(
    parameter int NT  = 2,
    parameter int NWB = 3
);
    logic [NT*32-1:0] in_wb_data;
    logic [4:0]       in_wb_rd;
    logic [1:0]       in_wb_wb;
    logic [NT-1:0]    in_wb_valid;
    logic [NWB-1:0]   in_wb_warp_num;
    logic [NWB-1:0]   in_rd_warp_num;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [NT*32-1:0] out_rs1_data;
    logic [NT*32-1:0] out_rs2_data;
    logic             in_clear_req;
    logic [NWB-1:0]   in_clear_warp;
    logic             out_clear_busy;
    logic             out_ready;

    modport master (
        output in_wb_data, in_wb_rd, in_wb_wb, in_wb_valid, in_wb_warp_num,
        output in_rd_warp_num, in_rs1, in_rs2, in_clear_req, in_clear_warp,
        input  out_rs1_data, out_rs2_data, out_clear_busy, out_ready
    );

    modport slave (
        input  in_wb_data, in_wb_rd, in_wb_wb, in_wb_valid, in_wb_warp_num,
        input  in_rd_warp_num, in_rs1, in_rs2, in_clear_req, in_clear_warp,
        output out_rs1_data, out_rs2_data, out_clear_busy, out_ready
    );
endinterface

// File: rtl/vx_gpr_wb_file.sv
// Per-warp GPR file with writeback port, two registered read ports,
// same-cycle forwarding and a sweeping clear engine (init + warp spawn).
module vx_gpr_wb_file #(
    parameter int NT       = 2,
    parameter int NW       = 8,
    parameter int NUM_REGS = 32,
    parameter int NWB      = (NW > 1) ? $clog2(NW) : 1
) (
    input logic             clk,
    input logic             reset,
    vx_gpr_wb_file_if.slave bus
);
    localparam int W  = NT * 32;
    localparam int CW = $clog2(NUM_REGS);
    localparam logic [CW-1:0] LAST = CW'(NUM_REGS - 1);

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NWB-1:0] cw_q, cw_d;

    logic                  we;
    logic [NW-1:0][W-1:0]  rd1_all;
    logic [NW-1:0][W-1:0]  rd2_all;
    logic [W-1:0]          rs1_fwd;
    logic [W-1:0]          rs2_fwd;

    assign we = (bus.in_wb_wb != 2'b00) && (bus.in_wb_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        unique case (state_q)
            INIT, CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (bus.in_clear_req) begin
                    state_d = CLEAR;
                    cw_d    = bus.in_clear_warp;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.out_ready      = (state_q == IDLE);
    assign bus.out_clear_busy = (state_q != IDLE);

    // One storage column per warp/lane; the wb write follows the clear
    // so that on a collision wb wins its valid lanes and others are zeroed.
    for (genvar w = 0; w < NW; w++) begin : g_warp
        logic clr;
        logic wr;
        assign clr = (state_q == INIT) ||
                     ((state_q == CLEAR) && (cw_q == NWB'(w)));
        assign wr  = we && (bus.in_wb_warp_num == NWB'(w));
        for (genvar i = 0; i < NT; i++) begin : g_lane
            logic [31:0] cells [NUM_REGS];
            always_ff @(posedge clk) begin
                if (clr)
                    cells[cnt_q] <= '0;
                if (wr && bus.in_wb_valid[i])
                    cells[bus.in_wb_rd] <= bus.in_wb_data[32*i +: 32];
            end
            assign rd1_all[w][32*i +: 32] = cells[bus.in_rs1];
            assign rd2_all[w][32*i +: 32] = cells[bus.in_rs2];
        end
    end

    always_comb begin
        rs1_fwd = rd1_all[bus.in_rd_warp_num];
        rs2_fwd = rd2_all[bus.in_rd_warp_num];
        for (int i = 0; i < NT; i++) begin
            if (we && bus.in_wb_valid[i] &&
                (bus.in_wb_warp_num == bus.in_rd_warp_num)) begin
                if (bus.in_wb_rd == bus.in_rs1)
                    rs1_fwd[32*i +: 32] = bus.in_wb_data[32*i +: 32];
                if (bus.in_wb_rd == bus.in_rs2)
                    rs2_fwd[32*i +: 32] = bus.in_wb_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
        end else begin
            bus.out_rs1_data <= (bus.in_rs1 == 5'd0) ? '0 : rs1_fwd;
            bus.out_rs2_data <= (bus.in_rs2 == 5'd0) ? '0 : rs2_fwd;
        end
    end
endmodule

// File: tb/tb_vx_gpr_wb_file.sv
// Self-checking bench for vx_gpr_wb_file: reference model of storage and
// clear engine, read results queued at issue and compared on return.
module tb_vx_gpr_wb_file;
    localparam int NT  = 2;
    localparam int NW  = 8;
    localparam int NWB = 3;
    localparam int NR  = 32;
    localparam int S_INIT = 0, S_IDLE = 1, S_CLEAR = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_gpr_wb_file_if #(.NT(NT), .NWB(NWB)) ifc ();

    vx_gpr_wb_file #(.NT(NT), .NW(NW), .NUM_REGS(NR)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          v;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem_m [NW][NR];
    int          mstate = S_INIT;
    int          mcnt = 0;
    int          mcw = 0;
    bit          known = 0;
    int          passed = 0;
    int          total = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        exp_t        e;
        logic [63:0] s1, s2;
        bit          we;
        we = (ifc.in_wb_wb != 2'b00) && (ifc.in_wb_rd != 5'd0);
        s1 = mem_m[ifc.in_rd_warp_num][ifc.in_rs1];
        s2 = mem_m[ifc.in_rd_warp_num][ifc.in_rs2];
        for (int i = 0; i < NT; i++)
            if (we && ifc.in_wb_valid[i] &&
                ifc.in_wb_warp_num == ifc.in_rd_warp_num) begin
                if (ifc.in_wb_rd == ifc.in_rs1)
                    s1[32*i +: 32] = ifc.in_wb_data[32*i +: 32];
                if (ifc.in_wb_rd == ifc.in_rs2)
                    s2[32*i +: 32] = ifc.in_wb_data[32*i +: 32];
            end
        if (ifc.in_rs1 == 5'd0 || !reset) s1 = '0;
        if (ifc.in_rs2 == 5'd0 || !reset) s2 = '0;
        e.a = s1;
        e.b = s2;
        e.v = known || !reset;
        sb.push_back(e);
        if (mstate == S_INIT)
            for (int w = 0; w < NW; w++) mem_m[w][mcnt] = '0;
        else if (mstate == S_CLEAR)
            mem_m[mcw][mcnt] = '0;
        for (int i = 0; i < NT; i++)
            if (we && ifc.in_wb_valid[i])
                mem_m[ifc.in_wb_warp_num][ifc.in_wb_rd][32*i +: 32] =
                    ifc.in_wb_data[32*i +: 32];
        if (!reset) begin
            mstate = S_INIT;
            mcnt = 0;
        end else if (mstate == S_IDLE) begin
            if (ifc.in_clear_req) begin
                mstate = S_CLEAR;
                mcw = int'(ifc.in_clear_warp);
                mcnt = 0;
            end
        end else if (mcnt == NR - 1) begin
            if (mstate == S_INIT) known = 1;
            mstate = S_IDLE;
            mcnt = 0;
        end else begin
            mcnt++;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.v) begin
            check("rs1_data", ifc.out_rs1_data, e.a);
            check("rs2_data", ifc.out_rs2_data, e.b);
        end
        check("ready", 64'(ifc.out_ready), 64'(mstate == S_IDLE));
        check("busy", 64'(ifc.out_clear_busy), 64'(mstate != S_IDLE));
    endtask

    task automatic set_wb(input int w, input int rd, input logic [1:0] code,
                          input logic [1:0] vld, input logic [63:0] d);
        ifc.in_wb_warp_num = NWB'(w);
        ifc.in_wb_rd       = 5'(rd);
        ifc.in_wb_wb       = code;
        ifc.in_wb_valid    = vld;
        ifc.in_wb_data     = d;
    endtask

    task automatic set_rd(input int w, input int r1, input int r2);
        ifc.in_rd_warp_num = NWB'(w);
        ifc.in_rs1         = 5'(r1);
        ifc.in_rs2         = 5'(r2);
    endtask

    task automatic wait_idle(input string tag, input int exp_n);
        int n = 0;
        while (!ifc.out_ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        set_wb(0, 0, 2'b00, 2'b00, '0);
        set_rd(0, 0, 0);
        ifc.in_clear_req  = 1'b0;
        ifc.in_clear_warp = '0;
        repeat (3) tick();
        check("rst_ready", 64'(ifc.out_ready), 64'd0);
        check("rst_busy", 64'(ifc.out_clear_busy), 64'd1);
        check("rst_rs1", ifc.out_rs1_data, 64'd0);
        reset = 1'b1;
        wait_idle("init_len", 32);
        for (int k = 0; k < 8; k++) begin
            set_rd($urandom_range(0, NW - 1), $urandom_range(0, 31),
                   $urandom_range(0, 31));
            tick();
        end

        set_wb(2, 5, 2'b01, 2'b11, {32'hB, 32'hA});
        tick();
        set_wb(0, 0, 2'b00, 2'b00, '0);
        set_rd(2, 5, 0);
        tick();
        check("t2_read", ifc.out_rs1_data, {32'hB, 32'hA});

        set_wb(1, 7, 2'b01, 2'b11, {32'h9, 32'h8});
        tick();
        set_wb(1, 7, 2'b10, 2'b01, {32'hDEAD, 32'h55});
        set_rd(1, 0, 7);
        tick();
        check("t3_fwd", ifc.out_rs2_data, {32'h9, 32'h55});
        set_wb(1, 0, 2'b01, 2'b11, {32'h1111, 32'h2222});
        tick();
        set_wb(1, 7, 2'b00, 2'b11, {32'h3333, 32'h4444});
        tick();
        set_wb(0, 0, 2'b00, 2'b00, '0);
        set_rd(1, 7, 0);
        tick();
        check("t3_nowrite", ifc.out_rs1_data, {32'h9, 32'h55});
        check("t3_r0", ifc.out_rs2_data, 64'd0);

        for (int r = 1; r < NR; r++) begin
            set_wb(3, r, 2'b01, 2'b11, {32'(r + 100), 32'(r)});
            tick();
            set_wb(4, r, 2'b10, 2'b11, {32'(r + 200), 32'(r + 50)});
            tick();
        end
        set_wb(0, 0, 2'b00, 2'b00, '0);
        ifc.in_clear_req  = 1'b1;
        ifc.in_clear_warp = 3'd3;
        tick();
        ifc.in_clear_req = 1'b0;
        begin
            int n = 0;
            while (ifc.out_clear_busy && n < 100) begin
                if (n == 5) begin
                    ifc.in_clear_req  = 1'b1;
                    ifc.in_clear_warp = 3'd4;
                end
                tick();
                ifc.in_clear_req = 1'b0;
                n++;
            end
            check("t4_busy_len", 64'(n), 64'd32);
        end
        for (int r = 0; r < NR; r += 2) begin
            set_rd(3, r, r + 1);
            tick();
        end
        for (int r = 0; r < NR; r += 2) begin
            set_rd(4, r, r + 1);
            tick();
        end
        set_rd(3, 9, 31);
        tick();
        check("t4_cleared", ifc.out_rs1_data, 64'd0);
        set_rd(4, 9, 31);
        tick();
        check("t4_intact", ifc.out_rs1_data, {32'd209, 32'd59});

        set_wb(0, 4, 2'b01, 2'b11, {32'd22, 32'd11});
        tick();
        set_wb(0, 0, 2'b00, 2'b00, '0);
        ifc.in_clear_req  = 1'b1;
        ifc.in_clear_warp = 3'd0;
        tick();
        ifc.in_clear_req = 1'b0;
        repeat (4) tick();
        set_wb(0, 4, 2'b01, 2'b10, {32'd77, 32'd66});
        tick();
        set_wb(0, 0, 2'b00, 2'b00, '0);
        wait_idle("t5_busy_len", 27);
        set_rd(0, 4, 5);
        tick();
        check("t5_collide", ifc.out_rs1_data, {32'd77, 32'd0});

        ifc.in_clear_req  = 1'b1;
        ifc.in_clear_warp = 3'd5;
        tick();
        ifc.in_clear_req = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        check("t6_rst_ready", 64'(ifc.out_ready), 64'd0);
        reset = 1'b1;
        wait_idle("t6_init_len", 32);
        set_rd(4, 9, 5);
        tick();
        check("t6_zero", ifc.out_rs1_data, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
